// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table, pi/2 and the vectoring FSM state type.
package cordic_pkg;

  localparam int ANGLE_FRAC = 14;
  localparam logic signed [15:0] PI_OVER_2 = 16'sh6488;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_e;

  // atan(2^-idx) in Q2.14, truncated; identical to the rotation-mode table.
  function automatic logic signed [15:0] atan_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    return 16'sh3243;
      4'd1:    return 16'sh1DAC;
      4'd2:    return 16'sh0FAD;
      4'd3:    return 16'sh07F5;
      4'd4:    return 16'sh03FE;
      4'd5:    return 16'sh01FF;
      4'd6:    return 16'sh00FF;
      4'd7:    return 16'sh007F;
      4'd8:    return 16'sh003F;
      4'd9:    return 16'sh001F;
      4'd10:   return 16'sh000F;
      4'd11:   return 16'sh0007;
      4'd12:   return 16'sh0003;
      4'd13:   return 16'sh0001;
      default: return 16'sh0000;
    endcase
  endfunction

  // Re-express a Q.14 angle constant with `frac` fractional bits.
  function automatic logic signed [31:0] scale_angle(input logic signed [15:0] c, input int frac);
    if (frac >= ANGLE_FRAC) return 32'(c) <<< (frac - ANGLE_FRAC);
    return 32'(c) >>> (ANGLE_FRAC - frac);
  endfunction

endpackage

// File: rtl/cordic_vector_step.sv
// One vectoring-mode micro-rotation: drives y toward zero and accumulates the angle in z.
module cordic_vector_step
  import cordic_pkg::*;
#(
  parameter int W    = 18,
  parameter int ZW   = 17,
  parameter int FRAC = 14
) (
  input  logic signed [W-1:0]  x_i,
  input  logic signed [W-1:0]  y_i,
  input  logic signed [ZW-1:0] z_i,
  input  logic        [3:0]    idx_i,
  output logic signed [W-1:0]  x_o,
  output logic signed [W-1:0]  y_o,
  output logic signed [ZW-1:0] z_o
);

  logic signed [W-1:0]  x_sh;
  logic signed [W-1:0]  y_sh;
  logic signed [ZW-1:0] atan;

  always_comb begin
    x_sh = x_i >>> idx_i;
    y_sh = y_i >>> idx_i;
    atan = ZW'(scale_angle(atan_entry(idx_i), FRAC));
    if (!y_i[W-1]) begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + atan;
    end else begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - atan;
    end
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring CORDIC: (x, y) -> (K*|v|, atan2(y, x)), one micro-rotation per clock.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 14,
  parameter int ITERS = 14
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH+1:0] mag_out,
  output logic signed [WIDTH:0]   angle_out
);

  localparam int XW = WIDTH + 2;
  // The angle never leaves (-4, 4), so z only needs the Q3.14 output range.
  localparam int ZW = WIDTH + 1;
  localparam logic [3:0] LAST = 4'(ITERS - 1);
  localparam logic signed [ZW-1:0] PI_HALF = ZW'(scale_angle(PI_OVER_2, FRAC));

  state_e               state_q;
  logic [3:0]           i_q;
  logic signed [XW-1:0] x_q, x_d, x_nxt, x_ext;
  logic signed [XW-1:0] y_q, y_d, y_nxt, y_ext;
  logic signed [ZW-1:0] z_q, z_d, z_nxt;
  logic                 zero_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 accept;

  assign x_ext  = XW'(x_in);
  assign y_ext  = XW'(y_in);
  assign accept = (state_q == IDLE) && in_valid && in_ready_q;

  cordic_vector_step #(
    .W   (XW),
    .ZW  (ZW),
    .FRAC(FRAC)
  ) u_step (
    .x_i  (x_q),
    .y_i  (y_q),
    .z_i  (z_q),
    .idx_i(i_q),
    .x_o  (x_nxt),
    .y_o  (y_nxt),
    .z_o  (z_nxt)
  );

  always_comb begin
    // NOTE: hold values are assigned first so every path drives x_d/y_d/z_d and no latch is inferred.
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    if (accept) begin
      if (!x_in[WIDTH-1]) begin
        x_d = x_ext;
        y_d = y_ext;
        z_d = '0;
      end else if (!y_in[WIDTH-1]) begin
        x_d = y_ext;
        y_d = -x_ext;
        z_d = PI_HALF;
      end else begin
        x_d = -y_ext;
        y_d = x_ext;
        z_d = -PI_HALF;
      end
    end else if (state_q == ITER) begin
      x_d = x_nxt;
      y_d = y_nxt;
      z_d = z_nxt;
    end
  end

  // NOTE: every register, datapath included, is cleared by reset so an aborted result never resurfaces.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      i_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q    <= ITER;
            i_q        <= '0;
            in_ready_q <= 1'b0;
            zero_q     <= (x_in == '0) && (y_in == '0);
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ITER: begin
          if (i_q == LAST) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            i_q <= i_q + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign mag_out   = x_q;
  assign angle_out = zero_q ? '0 : z_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed and randomised checks of cordic_vectoring against hand values and an atan2/hypot model.
module tb_cordic_vectoring;

  localparam real PI   = 3.14159265358979;
  localparam real K    = 1.64676025812107;
  localparam real SCL  = 16384.0;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] x_in;
  logic signed [15:0] y_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [17:0] mag_out;
  logic signed [16:0] angle_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cordic_vectoring #(
    .WIDTH(16),
    .FRAC (14),
    .ITERS(14)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .y_in     (y_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .mag_out  (mag_out),
    .angle_out(angle_out)
  );

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input longint obs, input longint exp, input longint tol);
    longint d;
    d = obs - exp;
    if (d < 0) d = -d;
    tests++;
    assert ((d <= tol) === 1'b1)
    else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  // Offer one sample from IDLE and wait for the result; edges counts the acceptance edge as 1.
  task automatic send(input int xi, input int yi, output int edges);
    @(negedge clk);
    x_in     = 16'(xi);
    y_in     = 16'(yi);
    in_valid = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check_eq("result_timeout", longint'(out_valid), 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  int          edges;
  int          xi, yi;
  real         r, em, ea;
  logic [36:0] held;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_in      = '0;
    y_in      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", longint'(in_ready), 0);
    check_eq("rst_out_valid", longint'(out_valid), 0);
    check_eq("rst_mag", mag_out, 0);
    check_eq("rst_angle", angle_out, 0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("post_rst_in_ready", longint'(in_ready), 1);

    // Angle 0: latency and K*1.0 magnitude.
    send(16'h4000, 0, edges);
    check_eq("latency", edges, 15);
    check_near("x1_mag", mag_out, 26981, 4);
    check_near("x1_angle", angle_out, 0, 4);
    drain();
    check_eq("handshake_drop", longint'(out_valid), 0);

    send(0, 16'h4000, edges);
    check_near("y1_angle", angle_out, 25736, 4);
    check_near("y1_mag", mag_out, 26981, 4);
    drain();

    send(16'h4000, 16'h4000, edges);
    check_near("diag_angle", angle_out, 12868, 4);
    check_near("diag_mag", mag_out, 38155, 6);
    drain();

    send(-16384, 0, edges);
    check_near("negx_angle", angle_out, 51472, 4);
    check_near("negx_mag", mag_out, 26981, 4);
    drain();

    send(-16384, -1, edges);
    check_near("negxy_angle", angle_out, -51472, 4);
    check_near("negxy_mag", mag_out, 26981, 4);
    drain();

    send(0, 0, edges);
    check_eq("zero_mag", mag_out, 0);
    check_eq("zero_angle", angle_out, 0);
    drain();

    // x = -2.0 needs the two guard bits during pre-rotation.
    send(-32768, 0, edges);
    check_near("min_x_mag", mag_out, 53962, 8);
    check_near("min_x_angle", angle_out, 51472, 8);
    drain();

    // Backpressure: outputs frozen, a new offer is ignored until after the handshake.
    send(16'h4000, 16'h4000, edges);
    check_near("bp_angle", angle_out, 12868, 4);
    held     = {out_valid, in_ready, mag_out, angle_out};
    x_in     = 16'h0000;
    y_in     = 16'h4000;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("bp_hold", {out_valid, in_ready, mag_out, angle_out}, {1'b1, 1'b0, held[34:0]});
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("bp_release_valid", longint'(out_valid), 0);
    check_eq("bp_release_ready", longint'(in_ready), 1);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("bp_accepted", longint'(in_ready), 0);
    while (out_valid !== 1'b1 && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check_eq("bp_latency", edges, 15);
    check_near("bp_next_angle", angle_out, 25736, 4);
    drain();

    // Reset during iteration 5.
    @(negedge clk);
    x_in     = 16'h4000;
    y_in     = 16'h4000;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("iter_rst_valid", longint'(out_valid), 0);
    check_eq("iter_rst_mag", mag_out, 0);
    check_eq("iter_rst_angle", angle_out, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset while a result is waiting in DONE must drop it without a clock.
    send(16'h4000, 0, edges);
    #2 reset = 1'b1;
    #1;
    check_eq("done_rst_valid", longint'(out_valid), 0);
    check_eq("done_rst_mag", mag_out, 0);
    check_eq("done_rst_ready", longint'(in_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("no_stale_valid", longint'(out_valid), 0);
    end
    check_eq("rerun_ready", longint'(in_ready), 1);
    send(16'h4000, 0, edges);
    check_near("rerun_mag", mag_out, 26981, 4);
    check_near("rerun_angle", angle_out, 0, 4);
    drain();

    // Random vectors with radius >= 0.5 against a real-valued model.
    for (int n = 0; n < 1000; n++) begin
      do begin
        xi = int'($urandom_range(0, 65535)) - 32768;
        yi = int'($urandom_range(0, 65535)) - 32768;
        r  = $sqrt(real'(xi) * real'(xi) + real'(yi) * real'(yi));
      end while (r < 8192.0);
      em = K * r;
      ea = $atan2(real'(yi), real'(xi)) * SCL;
      send(xi, yi, edges);
      if (real'(angle_out) - ea > PI * SCL) ea = ea + 2.0 * PI * SCL;
      if (ea - real'(angle_out) > PI * SCL) ea = ea - 2.0 * PI * SCL;
      check_near("rand_mag", mag_out, longint'(em), 20);
      check_near("rand_angle", angle_out, longint'(ea), 40);
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
